alu_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational ALU among NREQ requesters. Each requester submits {op, rs1, rs2} with a valid/ready handshake. The arbiter registers the winning request, presents it to the ALU for one cycle, captures rd/flag, and returns them on that requester's response channel. It sits between the issue stages of the requester pipelines and the ALU instance, and is the only driver of the ALU inputs.

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Each operation runs IDLE (handshake) -> ISSUE (ALU evaluates) -> RESP (result returned).
//
// Handshake rules, for both channels:
//   A request transfers on a rising edge where req_valid[i] and req_ready[i] are both high.
//   A response transfers on a rising edge where rsp_valid[i] and rsp_ready[i] are both high.
//   req_ready is at most one-hot and is asserted only in IDLE.
//   rsp_valid is at most one-hot and is held, with stable data, until it is accepted.
//   A requester may drop valid without a transfer.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [4*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_rs1,
    input  logic [WIDTH*NREQ-1:0] req_rs2,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_rd,
    output logic [2:0]            rsp_flag,
    output logic [3:0]            alu_op,
    output logic [WIDTH-1:0]      alu_rs1,
    output logic [WIDTH-1:0]      alu_rs2,
    input  logic [WIDTH-1:0]      alu_rd,
    input  logic [2:0]            alu_flag,
    output logic                  busy,
    output logic [7:0]            illegal_count,
    output logic [1:0]            dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     last_grant_q, last_grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [WIDTH-1:0]  alu_rs1_q, alu_rs1_d;
    logic [WIDTH-1:0]  alu_rs2_q, alu_rs2_d;
    logic [WIDTH-1:0]  rsp_rd_q, rsp_rd_d;
    logic [2:0]        rsp_flag_q, rsp_flag_d;
    logic [7:0]        illegal_count_q, illegal_count_d;

    logic              grant_found;
    logic [IW-1:0]     grant_idx;
    int                cand;

    // Priority starts just after the last completed owner and wraps around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant_q) + k) % NREQ;
            if (!grant_found && req_valid[cand[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        owner_d         = owner_q;
        alu_op_d        = alu_op_q;
        alu_rs1_d       = alu_rs1_q;
        alu_rs2_d       = alu_rs2_q;
        rsp_rd_d        = rsp_rd_q;
        rsp_flag_d      = rsp_flag_q;
        illegal_count_d = illegal_count_q;
        req_ready       = '0;
        rsp_valid       = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    owner_d   = grant_idx;
                    alu_op_d  = req_op[int'(grant_idx)*4 +: 4];
                    alu_rs1_d = req_rs1[int'(grant_idx)*WIDTH +: WIDTH];
                    alu_rs2_d = req_rs2[int'(grant_idx)*WIDTH +: WIDTH];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // The ALU result is undefined for an illegal opcode, so return zero instead.
                rsp_rd_d   = alu_flag[2] ? '0 : alu_rd;
                rsp_flag_d = alu_flag;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                    if (rsp_flag_q[2] && illegal_count_q != 8'hFF) begin
                        illegal_count_d = illegal_count_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            last_grant_q    <= IW'(NREQ - 1);
            owner_q         <= '0;
            alu_op_q        <= '0;
            alu_rs1_q       <= '0;
            alu_rs2_q       <= '0;
            rsp_rd_q        <= '0;
            rsp_flag_q      <= '0;
            illegal_count_q <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            owner_q         <= owner_d;
            alu_op_q        <= alu_op_d;
            alu_rs1_q       <= alu_rs1_d;
            alu_rs2_q       <= alu_rs2_d;
            rsp_rd_q        <= rsp_rd_d;
            rsp_flag_q      <= rsp_flag_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign alu_op        = alu_op_q;
    assign alu_rs1       = alu_rs1_q;
    assign alu_rs2       = alu_rs2_q;
    assign rsp_rd        = rsp_rd_q;
    assign rsp_flag      = rsp_flag_q;
    assign illegal_count = illegal_count_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small reference ALU drives alu_rd/alu_flag.
// Expected values are hand-computed constants.
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 2;

    logic                  clk;
    logic                  resetn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [4*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_rs1;
    logic [WIDTH*NREQ-1:0] req_rs2;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_rd;
    logic [2:0]            rsp_flag;
    logic [3:0]            alu_op;
    logic [WIDTH-1:0]      alu_rs1;
    logic [WIDTH-1:0]      alu_rs2;
    logic [WIDTH-1:0]      alu_rd;
    logic [2:0]            alu_flag;
    logic                  busy;
    logic [7:0]            illegal_count;
    logic [1:0]            dbg_state;

    int n_vec;
    int n_err;

    alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rd(rsp_rd), .rsp_flag(rsp_flag),
        .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_rd(alu_rd), .alu_flag(alu_flag),
        .busy(busy), .illegal_count(illegal_count), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 1 ADD, 2 SUB, 5 XOR, 6 SLL; 0/13/14/15 are illegal and return garbage.
    logic [WIDTH:0] tmp;
    always_comb begin
        tmp      = '0;
        alu_rd   = alu_rs1;
        alu_flag = 3'b000;
        case (alu_op)
            4'd1: begin
                tmp      = {1'b0, alu_rs1} + {1'b0, alu_rs2};
                alu_rd   = tmp[WIDTH-1:0];
                alu_flag = {1'b0, tmp[WIDTH], 1'b0};
            end
            4'd2: begin
                tmp      = {1'b0, alu_rs1} - {1'b0, alu_rs2};
                alu_rd   = tmp[WIDTH-1:0];
                alu_flag = {2'b00, (alu_rs1 < alu_rs2)};
            end
            4'd5: alu_rd = alu_rs1 ^ alu_rs2;
            4'd6: alu_rd = alu_rs1 << alu_rs2[3:0];
            4'd0, 4'd13, 4'd14, 4'd15: begin
                alu_rd   = 16'hDEAD;
                alu_flag = 3'b100;
            end
            default: alu_rd = alu_rs1;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 2 time units after a rising edge; inputs are driven then, checks follow #1 later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int idx, input logic [3:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_op[idx*4 +: 4]          = op;
        req_rs1[idx*WIDTH +: WIDTH] = a;
        req_rs2[idx*WIDTH +: WIDTH] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] iop;
        n_vec = 0;
        n_err = 0;
        req_valid = '0; req_op = '0; req_rs1 = '0; req_rs2 = '0;
        rsp_ready = '0; resetn = 1'b0;
        #3;
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_rs1", alu_rs1, 0);
        chk("rst_rsp_rd", rsp_rd, 0);
        chk("rst_rsp_flag", rsp_flag, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_illegal_count", illegal_count, 0);
        chk("rst_state", dbg_state, 0);
        step(); resetn = 1'b1; #1;
        chk("idle_no_req", req_ready, 0);

        // Single ADD: 0xFFFF + 1 wraps to 0 with carry.
        set_req(0, 4'd1, 16'hFFFF, 16'h0001); req_valid = 2'b01; rsp_ready = 2'b11; #1;
        chk("single_req_ready", req_ready, 2'b01);
        chk("single_busy_idle", busy, 0);
        step(); req_valid = 2'b00; #1;
        chk("single_busy_issue", busy, 1);
        chk("single_alu_op", alu_op, 4'd1);
        chk("single_alu_rs1", alu_rs1, 16'hFFFF);
        chk("single_alu_rs2", alu_rs2, 16'h0001);
        chk("single_no_rsp_issue", rsp_valid, 0);
        step(); #1;
        chk("single_rsp_valid", rsp_valid, 2'b01);
        chk("single_rsp_rd", rsp_rd, 16'h0000);
        chk("single_rsp_flag", rsp_flag, 3'b010);
        chk("single_busy_resp", busy, 1);
        step(); #1;
        chk("single_busy_done", busy, 0);
        chk("single_rsp_dropped", rsp_valid, 0);
        chk("single_alu_op_held", alu_op, 4'd1);

        // Contention after reset: grants alternate 0,1,0,1.
        resetn = 1'b0; #1; resetn = 1'b1;
        set_req(0, 4'd2, 16'd5, 16'd7);
        set_req(1, 4'd5, 16'h00FF, 16'h0F0F);
        req_valid = 2'b11; #1;
        chk("cont_grant0", req_ready, 2'b01);
        step(); #1;
        chk("cont_alu_op_sub", alu_op, 4'd2);
        step(); #1;
        chk("cont_rsp0_valid", rsp_valid, 2'b01);
        chk("cont_rsp0_rd", rsp_rd, 16'hFFFE);
        chk("cont_rsp0_flag", rsp_flag, 3'b001);
        step(); #1;
        chk("cont_grant1", req_ready, 2'b10);
        step(); #1;
        chk("cont_alu_op_xor", alu_op, 4'd5);
        chk("cont_alu_rs1_xor", alu_rs1, 16'h00FF);
        step(); #1;
        chk("cont_rsp1_valid", rsp_valid, 2'b10);
        chk("cont_rsp1_rd", rsp_rd, 16'h0FF0);
        chk("cont_rsp1_flag", rsp_flag, 3'b000);
        step(); #1;
        chk("cont_grant0_again", req_ready, 2'b01);
        step(); step(); #1;
        chk("cont_rsp0_again", rsp_valid, 2'b01);
        chk("cont_rsp0_rd_again", rsp_rd, 16'hFFFE);
        step(); #1;
        chk("cont_grant1_again", req_ready, 2'b10);
        req_valid = 2'b00; #1;
        chk("cont_ready_follows_valid", req_ready, 2'b00);

        // Backpressure on requester 1 while requester 0 waits.
        step();
        set_req(1, 4'd6, 16'h0001, 16'h0004);
        set_req(0, 4'd1, 16'd3, 16'd4);
        req_valid = 2'b10; rsp_ready = 2'b00; #1;
        chk("bp_grant1", req_ready, 2'b10);
        step(); req_valid = 2'b11; #1;
        chk("bp_issue_no_ready", req_ready, 2'b00);
        chk("bp_alu_op_sll", alu_op, 4'd6);
        step(); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid_held", rsp_valid, 2'b10);
            chk("bp_rsp_rd_stable", rsp_rd, 16'h0010);
            chk("bp_req_ready_low", req_ready, 2'b00);
            step(); #1;
        end
        rsp_ready = 2'b10; #1;
        chk("bp_no_comb_ready", req_ready, 2'b00);
        chk("bp_rsp_still_valid", rsp_valid, 2'b10);
        step(); rsp_ready = 2'b11; #1;
        chk("bp_grant0_after", req_ready, 2'b01);
        chk("bp_idle", busy, 0);
        step(); req_valid = 2'b00; #1;
        chk("bp_alu_rs1_req0", alu_rs1, 16'd3);
        step(); #1;
        chk("bp_rsp0_valid", rsp_valid, 2'b01);
        chk("bp_rsp0_rd", rsp_rd, 16'd7);
        step(); #1;

        // Illegal opcode: forwarded unchanged, result forced to zero, counted.
        set_req(0, 4'hF, 16'h1234, 16'h5678); req_valid = 2'b01; #1;
        chk("ill_grant", req_ready, 2'b01);
        step(); req_valid = 2'b00; #1;
        chk("ill_alu_op_fwd", alu_op, 4'hF);
        step(); #1;
        chk("ill_rsp_valid", rsp_valid, 2'b01);
        chk("ill_rsp_flag", rsp_flag, 3'b100);
        chk("ill_rsp_rd_zero", rsp_rd, 16'h0000);
        step(); #1;
        chk("ill_count_one", illegal_count, 8'd1);

        for (int i = 0; i < 300; i++) begin
            case (i % 4)
                0: iop = 4'd0;
                1: iop = 4'd13;
                2: iop = 4'd14;
                default: iop = 4'd15;
            endcase
            set_req(0, iop, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            req_valid = 2'b01;
            step(); step(); step();
            if (i == 252) begin
                #1;
                chk("ill_count_254", illegal_count, 8'd254);
            end
        end
        req_valid = 2'b00; #1;
        chk("ill_count_sat", illegal_count, 8'd255);
        chk("ill_rd_zero_last", rsp_rd, 16'h0000);

        // Reset during ISSUE aborts the operation.
        set_req(0, 4'd1, 16'd1, 16'd1); req_valid = 2'b01;
        step(); req_valid = 2'b00; #1;
        chk("rmid_in_issue", dbg_state, 2'd1);
        resetn = 1'b0; #1;
        chk("rmid_busy", busy, 0);
        chk("rmid_alu_op", alu_op, 0);
        chk("rmid_alu_rs1", alu_rs1, 0);
        chk("rmid_rsp_flag", rsp_flag, 0);
        chk("rmid_rsp_valid", rsp_valid, 0);
        chk("rmid_count", illegal_count, 0);
        step(); #1;
        chk("rmid_no_rsp_pulse", rsp_valid, 0);
        resetn = 1'b1;
        set_req(1, 4'd1, 16'd2, 16'd3); req_valid = 2'b10; #1;
        chk("rmid_grant1", req_ready, 2'b10);
        step(); req_valid = 2'b00;
        step(); #1;
        chk("rmid_rsp1_valid", rsp_valid, 2'b10);
        chk("rmid_rsp1_rd", rsp_rd, 16'd5);
        step(); #1;
        set_req(0, 4'd5, 16'hF0F0, 16'hFFFF); req_valid = 2'b11; #1;
        chk("rmid_tie_grant0", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        step(); #1;
        chk("rmid_rsp0_rd", rsp_rd, 16'h0F0F);
        step(); #1;

        // Withdrawn request from requester 0 while requester 1 is in RESP.
        set_req(1, 4'd1, 16'd1, 16'd2); req_valid = 2'b10; rsp_ready = 2'b00; #1;
        chk("wd_grant1", req_ready, 2'b10);
        step(); req_valid = 2'b00;
        step(); req_valid = 2'b01; #1;
        chk("wd_resp1", rsp_valid, 2'b10);
        chk("wd_no_grant0", req_ready, 2'b00);
        step(); req_valid = 2'b00; rsp_ready = 2'b10; #1;
        chk("wd_rsp1_rd", rsp_rd, 16'd3);
        step(); rsp_ready = 2'b11; #1;
        chk("wd_idle", busy, 0);
        chk("wd_no_rsp", rsp_valid, 0);
        req_valid = 2'b11; #1;
        chk("wd_last_grant1", req_ready, 2'b01);
        req_valid = 2'b00;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
